// File: rtl/case_run_tracker.sv
// Groups consecutive upper-case characters into runs and emits one {len, first, sat} record per run.
// Optional classifier cross-check enabled by defining CASE_RUN_TRACKER_CHECK_EN.
module case_run_tracker #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_upper,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] out_len,
  output logic [7:0]       out_first,
  output logic             out_sat,
  output logic [CNT_W-1:0] run_count,
  output logic             err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_nxt_s;
  logic [7:0]         first_r;
  logic [7:0]         first_nxt_s;
  logic               sat_r;
  logic               sat_nxt_s;

  logic               emit_s;
  logic [LEN_W-1:0]   emit_len_s;
  logic [7:0]         emit_first_s;
  logic               emit_sat_s;

  logic               out_valid_r;
  logic [LEN_W-1:0]   out_len_r;
  logic [7:0]         out_first_r;
  logic               out_sat_r;
  logic [CNT_W-1:0]   run_count_r;

  logic               accept_s;
  logic               out_accept_s;
  logic               len_max_s;
  logic [LEN_W-1:0]   len_inc_s;
  logic               sat_inc_s;

  // No character is taken while a record is pending, so accepts never overlap.
  assign in_ready     = !out_valid_r;
  assign accept_s     = in_valid && !out_valid_r;
  assign out_accept_s = out_valid_r && out_ready;

  assign len_max_s = (len_r == {LEN_W{1'b1}});
  assign len_inc_s = len_max_s ? len_r : (len_r + LEN_W'(1'b1));
  assign sat_inc_s = sat_r | len_max_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_upper && !in_last) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (!in_upper || in_last)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: next run registers and the record to emit
  always_comb begin
    len_nxt_s    = len_r;
    first_nxt_s  = first_r;
    sat_nxt_s    = sat_r;
    emit_s       = 1'b0;
    emit_len_s   = len_r;
    emit_first_s = first_r;
    emit_sat_s   = sat_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_upper) begin
          if (in_last) begin
            emit_s       = 1'b1;
            emit_len_s   = LEN_W'(1'b1);
            emit_first_s = in_char;
            emit_sat_s   = 1'b0;
          end else begin
            len_nxt_s    = LEN_W'(1'b1);
            first_nxt_s  = in_char;
            sat_nxt_s    = 1'b0;
          end
        end else begin
          emit_s = 1'b0;
        end
      end
      RUN: begin
        if (accept_s) begin
          if (in_upper) begin
            len_nxt_s = len_inc_s;
            sat_nxt_s = sat_inc_s;
            if (in_last) begin
              emit_s     = 1'b1;
              emit_len_s = len_inc_s;
              emit_sat_s = sat_inc_s;
            end else begin
              emit_s = 1'b0;
            end
          end else begin
            // The terminating lower-case character is not part of the run.
            emit_s = 1'b1;
          end
        end else begin
          emit_s = 1'b0;
        end
      end
      default: begin
        emit_s = 1'b0;
      end
    endcase
  end

  // Open-run registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r   <= '0;
      first_r <= 8'h00;
      sat_r   <= 1'b0;
    end else begin
      len_r   <= len_nxt_s;
      first_r <= first_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  // Single-entry output record; fields only load on emit so they hold while pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_len_r   <= '0;
      out_first_r <= 8'h00;
      out_sat_r   <= 1'b0;
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      out_len_r   <= emit_len_s;
      out_first_r <= emit_first_s;
      out_sat_r   <= emit_sat_s;
    end else if (out_accept_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Count of records taken by the consumer, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count_r <= '0;
    end else if (out_accept_s) begin
      run_count_r <= run_count_r + CNT_W'(1'b1);
    end
  end

  assign out_valid = out_valid_r;
  assign out_len   = out_len_r;
  assign out_first = out_first_r;
  assign out_sat   = out_sat_r;
  assign run_count = run_count_r;

`ifdef CASE_RUN_TRACKER_CHECK_EN
  logic err_r;

  function automatic logic class_mismatch(input logic [7:0] c, input logic up);
    return (up != ~c[5]);
  endfunction

  // Sticky flag for a classifier tag that disagrees with the character
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s && class_mismatch(in_char, in_upper)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;

  case_run_tracker_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept_s),
    .in_char  (in_char),
    .in_upper (in_upper)
  );
`else
  assign err = 1'b0;
`endif

endmodule

`ifdef CASE_RUN_TRACKER_CHECK_EN
module case_run_tracker_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       accept,
  input logic [7:0] in_char,
  input logic       in_upper
);
  // Flag any accepted character whose upper-case tag disagrees with bit 5
  always @(posedge clk) begin
    if (rst_n && accept) begin
      assert (in_upper == ~in_char[5])
        else $error("case_run_tracker: in_upper=%0b disagrees with in_char=%02h", in_upper, in_char);
    end
  end
endmodule
`endif
